// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data memory arbiter.
//   arb_state_t : arbiter FSM encodings (ARB, BURST, FORCE)
//   CPU_PORT    : index of the CPU MEM stage in grant vectors
//   DMA_PORT    : index of the DMA/UART loader in grant vectors
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      BURST = 2'd1,
      FORCE = 2'd2
   } arb_state_t;

   localparam int CPU_PORT = 0;
   localparam int DMA_PORT = 1;

endpackage

// File: rtl/dmem_arbiter_starve.sv
// Anti-starvation counter for the DMA port.
// Counts consecutive cycles in which the DMA requests but is not granted,
// saturating at MAX_WAIT, and flags the edge on which the count reaches
// MAX_WAIT so the arbiter can force-grant the DMA in the following cycle.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   dma_req     : DMA request
//   dma_gnt     : DMA grant this cycle
//   wait_cnt    : current denial count (4 bits)
//   force_next  : this cycle's denial brings wait_cnt to MAX_WAIT
module arb_starve_cnt #(
   parameter int MAX_WAIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dma_req,
   input  logic       dma_gnt,
   output logic [3:0] wait_cnt,
   output logic       force_next
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

   logic denied;

   assign denied     = dma_req & ~dma_gnt;
   assign force_next = denied & (wait_cnt == MAX_CNT - 4'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= 4'd0;
      end else if (!denied) begin
         wait_cnt <= 4'd0;
      end else if (wait_cnt != MAX_CNT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage (port 0) and the
// DMA/UART loader (port 1). CPU has fixed priority; the DMA may lock the bus
// for bursts and is force-granted for one cycle after MAX_WAIT denials.
// Grants are combinational; memory reads are combinational and writes occur
// on the rising edge, so a granted access completes in its grant cycle.
// Optional build macro: DMEM_ARB_STATS_EN adds saturating conflict/stall
// counters (stat_conflicts, stat_cpu_stalls).
// Ports:
//   clk, reset                               : clock, sync active-high reset
//   cpu_req/wr/byte/addr/wdata               : CPU access request
//   cpu_rdata, cpu_gnt, cpu_stall            : CPU response / pipeline freeze
//   dma_req/wr/byte/addr/wdata/lock          : DMA access request
//   dma_rdata, dma_gnt                       : DMA response
//   mem_MemWr/MemRead/WordorByte/addr/data_w : data memory controls
//   mem_data_r                               : data memory read data
//   stat_conflicts, stat_cpu_stalls          : (DMEM_ARB_STATS_EN only)
import dmem_arb_pkg::*;

module dmem_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic              cpu_byte,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_wr,
   input  logic              dma_byte,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [31:0]       dma_wdata,
   input  logic              dma_lock,
   output logic [31:0]       dma_rdata,
   output logic              dma_gnt,
   output logic              mem_MemWr,
   output logic              mem_MemRead,
   output logic              mem_WordorByte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data_w,
   input  logic [31:0]       mem_data_r
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_conflicts,
   output logic [15:0]       stat_cpu_stalls
`endif
);

   arb_state_t state_q, state_d;
   logic [1:0] gnt;
   logic       in_arb;
   logic       force_next;
   logic [3:0] wait_cnt;

   arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk       (clk),
      .reset     (reset),
      .dma_req   (dma_req),
      .dma_gnt   (gnt[DMA_PORT]),
      .wait_cnt  (wait_cnt),
      .force_next(force_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end

   // A BURST cycle that loses its lock (or request) is arbitrated as ARB.
   always_comb begin
      gnt     = 2'b00;
      in_arb  = 1'b0;
      state_d = ARB;
      case (state_q)
         BURST: begin
            if (dma_req && dma_lock) begin
               gnt[DMA_PORT] = 1'b1;
            end else begin
               in_arb = 1'b1;
            end
         end
         FORCE:   gnt[DMA_PORT] = dma_req;
         default: in_arb = 1'b1;
      endcase
      if (in_arb) begin
         gnt[CPU_PORT] = cpu_req;
         gnt[DMA_PORT] = dma_req & ~cpu_req;
      end
      if (reset) begin
         gnt = 2'b00;
      end
      if (gnt[DMA_PORT] && dma_lock) begin
         state_d = BURST;
      end else if (in_arb && force_next) begin
         state_d = FORCE;
      end
   end

   assign cpu_gnt   = gnt[CPU_PORT];
   assign dma_gnt   = gnt[DMA_PORT];
   assign cpu_stall = cpu_req & ~gnt[CPU_PORT] & ~reset;
   assign cpu_rdata = gnt[CPU_PORT] ? mem_data_r : 32'd0;
   assign dma_rdata = gnt[DMA_PORT] ? mem_data_r : 32'd0;

   always_comb begin
      mem_MemWr      = 1'b0;
      mem_MemRead    = 1'b0;
      mem_WordorByte = 1'b0;
      mem_addr       = '0;
      mem_data_w     = 32'd0;
      if (gnt[DMA_PORT]) begin
         mem_MemWr      = dma_wr;
         mem_MemRead    = ~dma_wr;
         mem_WordorByte = dma_byte;
         mem_addr       = dma_addr;
         mem_data_w     = dma_wdata;
      end else if (gnt[CPU_PORT]) begin
         mem_MemWr      = cpu_wr;
         mem_MemRead    = ~cpu_wr;
         mem_WordorByte = cpu_byte;
         mem_addr       = cpu_addr;
         mem_data_w     = cpu_wdata;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_conflicts  <= 16'd0;
         stat_cpu_stalls <= 16'd0;
      end else begin
         if (cpu_req && dma_req && stat_conflicts != 16'hFFFF) begin
            stat_conflicts <= stat_conflicts + 16'd1;
         end
         if (cpu_stall && stat_cpu_stalls != 16'hFFFF) begin
            stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU MEM stage (port 0) and the DMA/UART loader (port 1).
- Sits between the pipeline's MEM stage, the loader, and the data memory.
- Data memory reads are combinational and writes occur on the rising edge, so a granted access completes in its grant cycle.
- The arbiter owns priority, DMA burst locking, anti-starvation and the CPU stall.

Parameters:
- MAX_WAIT, 4: consecutive cycles the DMA may be denied before it is force-granted for one cycle (1..15).
- ADDR_W, 32: address width passed through.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- cpu_req  input  1  CPU access request (MemRead or MemWr active)
- cpu_wr  input  1  1 = write, 0 = read
- cpu_byte  input  1  WordorByte: 1 = byte, 0 = word
- cpu_addr  input  ADDR_W  byte address
- cpu_wdata  input  32  write data
- cpu_rdata  output  32  read data; valid when cpu_gnt=1
- cpu_gnt  output  1  access performed this cycle
- cpu_stall  output  1  cpu_req & ~cpu_gnt; freezes the pipeline
- dma_req  input  1  DMA request; held with stable fields until dma_gnt
- dma_wr, dma_byte, dma_addr, dma_wdata  input  1/1/ADDR_W/32  as for CPU
- dma_lock  input  1  request burst ownership; sampled with dma_req
- dma_rdata  output  32  read data; valid when dma_gnt=1
- dma_gnt  output  1  access performed this cycle
- mem_MemWr, mem_MemRead, mem_WordorByte  output  1  data memory controls
- mem_addr  output  ADDR_W  to data memory
- mem_data_w  output  32  to data memory
- mem_data_r  input  32  from data memory

Behaviour:
- Grants are combinational from the requests and the registered state. At most one grant per cycle.
- The memory bus is driven from the granted port. mem_MemWr = gnt & wr; mem_MemRead = gnt & ~wr.
- With no grant: all mem_* outputs are 0.
- Both rdata outputs are mem_data_r gated by their own grant, else 0.
- State machine (2-bit state, reset to ARB):
  - ARB: CPU has fixed priority. dma_gnt = dma_req & ~cpu_req.
    - dma_gnt with dma_lock=1 -> BURST.
    - wait_cnt reaching MAX_WAIT -> FORCE.
  - BURST: the DMA owns the bus. dma_gnt = dma_req; cpu_gnt = 0, so cpu_stall = cpu_req.
    - Return to ARB on the first cycle where dma_lock=0 or dma_req=0. That cycle is arbitrated as ARB.
  - FORCE: exactly one cycle. dma_gnt = dma_req; the CPU is stalled.
    - Next state is ARB. If dma_lock=1 and the DMA is granted, next state is BURST.
- wait_cnt (4-bit):
  - Increments each cycle dma_req & ~dma_gnt.
  - Clears on dma_gnt or ~dma_req.
  - Saturates at MAX_WAIT.
  - The FORCE transition is taken on the edge where the increment makes wait_cnt equal MAX_WAIT.
- Simultaneous requests in ARB (wait_cnt < MAX_WAIT): the CPU wins, the DMA waits.
- A DMA request dropped before grant is legal. wait_cnt clears and the state is unchanged.
- Reset behaviour (synchronous reset, including mid-burst):
  - State -> ARB, wait_cnt -> 0.
  - Grants are forced to 0 during the reset cycle, so all outputs are 0 and no memory write occurs.
- Addresses and byte lanes are passed through unmodified; the data memory performs lane selection.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds output stat_conflicts[15:0]: cycles with cpu_req & dma_req.
  - Adds output stat_cpu_stalls[15:0]: cycles with cpu_stall.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encodings ARB=2'd0, BURST=2'd1, FORCE=2'd2
  - port index constants CPU_PORT=0, DMA_PORT=1
- Optional sub-module arb_starve_cnt: the wait counter plus MAX_WAIT compare, emitting force_next.

Test Plan:
- CPU only: cpu_req=1 read, addr 0x10, mem_data_r=0xDEADBEEF -> cpu_gnt=1, cpu_rdata=0xDEADBEEF, cpu_stall=0, mem_MemRead=1.
- Conflict: cpu_req and dma_req both held high with MAX_WAIT=4 -> CPU granted for 4 cycles, dma_gnt=1 in cycle 5 with cpu_stall=1, CPU granted again in cycle 6.
- Burst: DMA byte writes with dma_lock=1 to 0x20..0x23 while cpu_req=1 -> 4 consecutive dma_gnt, mem_WordorByte=1, cpu_stall=1. Dropping dma_lock returns to ARB and the CPU is granted the same cycle.
- Idle: no requests -> all mem_* = 0, both rdata = 0, state stays ARB.
- Reset mid-burst: assert reset during the 2nd burst cycle -> no mem_MemWr that cycle. State ARB and wait_cnt=0 afterwards; the CPU is granted first after release.
- DMEM_ARB_STATS_EN defined: 6 conflict cycles -> stat_conflicts=6, stat_cpu_stalls=1.
